// File: rtl/mc_proc_controller_if.sv
// Control bus between the multi-cycle controller and the datapath/memory side.
// The master modport is the controller; the slave modport is the datapath and memory.
interface mc_proc_controller_if #(
  parameter int unsigned STATE_W = 4
);
  logic [7:0]         opcode;
  logic               cond;
  logic               halt;
  logic               mem_ack;
  logic               mem_req;
  logic               mem_we;
  logic               addr_sel;
  logic               ir_write;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic [7:0]         alu_control;
  logic               alusrc;
  logic               reg_write;
  logic               memto_reg;
  logic               jal;
  logic               retire;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, cond, halt, mem_ack,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           alu_control, alusrc, reg_write, memto_reg, jal, retire, state
  );

  modport slave (
    output opcode, cond, halt, mem_ack,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           alu_control, alusrc, reg_write, memto_reg, jal, retire, state
  );
endinterface

// File: rtl/mc_proc_controller.sv
// Multi-cycle processor control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath and a req/ack memory port, emitting per-state enables.
module mc_proc_controller #(
  parameter logic [7:0]  ALU_ADD = 8'h00,
  parameter int unsigned STATE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_proc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    ALUWB  = 4'd3,
    ADDR   = 4'd4,
    MEMRD  = 4'd5,
    LDWB   = 4'd6,
    MEMWR  = 4'd7,
    BR     = 4'd8,
    JMP    = 4'd9,
    HALTED = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    C_ALUR, C_ALUI, C_LW, C_SW, C_BCOND, C_JAL
  } class_e;

  state_e state_q, state_d;
  class_e op_class;

  logic       mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0] pc_src;
  logic [7:0] alu_control;
  logic       alusrc, reg_write, memto_reg, jal, retire;

  always_comb begin
    if (bus.opcode[4] && bus.opcode[5])      op_class = C_JAL;
    else if (bus.opcode[4] && bus.opcode[6]) op_class = C_SW;
    else if (bus.opcode[4])                  op_class = C_LW;
    else if (bus.opcode[7])                  op_class = C_ALUI;
    else if (bus.opcode[6])                  op_class = C_BCOND;
    else                                     op_class = C_ALUR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    alu_control = '0;
    alusrc      = 1'b0;
    reg_write   = 1'b0;
    memto_reg   = 1'b0;
    jal         = 1'b0;
    retire      = 1'b0;

    case (state_q)
      FETCH: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else begin
          mem_req = 1'b1;
          if (bus.mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end
        end
      end
      HALTED: begin
        if (!bus.halt) state_d = FETCH;
      end
      DECODE: begin
        case (op_class)
          C_LW, C_SW: state_d = ADDR;
          C_BCOND:    state_d = BR;
          C_JAL:      state_d = JMP;
          default:    state_d = EXEC;
        endcase
      end
      EXEC: begin
        alu_control = bus.opcode;
        alusrc      = (op_class == C_ALUI);
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        alusrc    = (op_class == C_ALUI);
        retire    = 1'b1;
        state_d   = FETCH;
      end
      ADDR: begin
        alu_control = ALU_ADD;
        alusrc      = 1'b1;
        state_d     = (op_class == C_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ack) state_d = LDWB;
      end
      LDWB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ack) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      BR: begin
        alu_control = bus.opcode;
        pc_write    = bus.cond;
        pc_src      = 2'd1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      JMP: begin
        reg_write   = 1'b1;
        jal         = 1'b1;
        pc_write    = 1'b1;
        pc_src      = 2'd2;
        alusrc      = 1'b1;
        alu_control = bus.opcode;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset gates outputs combinationally so mem_req and enables drop the moment rst_n falls.
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      addr_sel    = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'd0;
      alu_control = '0;
      alusrc      = 1'b0;
      reg_write   = 1'b0;
      memto_reg   = 1'b0;
      jal         = 1'b0;
      retire      = 1'b0;
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.addr_sel    = addr_sel;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.alu_control = alu_control;
  assign bus.alusrc      = alusrc;
  assign bus.reg_write   = reg_write;
  assign bus.memto_reg   = memto_reg;
  assign bus.jal         = jal;
  assign bus.retire      = retire;
  assign bus.state       = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_proc_controller.sv
// Bench for mc_proc_controller: per-instruction expected cycle traces built from the
// opcode class rules, replayed cycle by cycle against the controller outputs.
module tb_mc_proc_controller;
  localparam logic [7:0]  ALU_ADD = 8'h00;
  localparam int unsigned STATE_W = 4;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC = 4'd2, S_ALUWB = 4'd3,
                         S_ADDR = 4'd4, S_MEMRD = 4'd5, S_LDWB = 4'd6, S_MEMWR = 4'd7,
                         S_BR = 4'd8, S_JMP = 4'd9, S_HALTED = 4'd10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mc_proc_controller_if #(.STATE_W(STATE_W)) bus ();

  mc_proc_controller #(.ALU_ADD(ALU_ADD), .STATE_W(STATE_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, asel, irw, pcw;
    logic [1:0] pcsrc;
    logic [7:0] alu;
    logic       alusrc, rw, m2r, jal, ret;
    logic [3:0] st;
  } outs_t;

  // ack/cond/halt: 0 or 1 drive that value, -1 drives a random value the DUT must ignore
  typedef struct {
    outs_t o;
    int    ack;
    int    cnd;
    int    hlt;
    bit    op_dc;
  } step_t;

  step_t      q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] cur_op;

  function automatic outs_t z(input logic [3:0] st);
    outs_t r = '0;
    r.st = st;
    return r;
  endfunction

  // 0 ALUR, 1 ALUI, 2 LW, 3 SW, 4 BCOND, 5 JAL
  function automatic int op_class(input logic [7:0] op);
    if (op[4] && op[5]) return 5;
    if (op[4] && op[6]) return 3;
    if (op[4])          return 2;
    if (op[7])          return 1;
    if (op[6])          return 4;
    return 0;
  endfunction

  function automatic outs_t sample();
    outs_t r;
    r.req = bus.mem_req;   r.we = bus.mem_we;    r.asel = bus.addr_sel;
    r.irw = bus.ir_write;  r.pcw = bus.pc_write; r.pcsrc = bus.pc_src;
    r.alu = bus.alu_control; r.alusrc = bus.alusrc; r.rw = bus.reg_write;
    r.m2r = bus.memto_reg; r.jal = bus.jal;      r.ret = bus.retire;
    r.st = bus.state;
    return r;
  endfunction

  task automatic add(input outs_t o, input int ack, input int cnd, input int hlt, input bit op_dc);
    step_t s;
    s.o = o; s.ack = ack; s.cnd = cnd; s.hlt = hlt; s.op_dc = op_dc;
    q.push_back(s);
  endtask

  task automatic check(input string tag, input outs_t obs, input outs_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic play(input string name);
    step_t s;
    int    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.halt    = (s.hlt < 0) ? 1'($urandom) : 1'(s.hlt);
      bus.mem_ack = (s.ack < 0) ? 1'($urandom) : 1'(s.ack);
      bus.cond    = (s.cnd < 0) ? 1'($urandom) : 1'(s.cnd);
      bus.opcode  = s.op_dc ? 8'($urandom) : cur_op;
      #1;
      check($sformatf("%s.c%0d", name, n), sample(), s.o);
      n++;
    end
  endtask

  task automatic build_fetch(input int unsigned wf);
    outs_t o;
    for (int unsigned i = 0; i < wf; i++) begin
      o = z(S_FETCH); o.req = 1'b1;
      add(o, 0, -1, 0, 1'b1);
    end
    o = z(S_FETCH); o.req = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
    add(o, 1, -1, 0, 1'b1);
    add(z(S_DECODE), -1, -1, -1, 1'b0);
  endtask

  task automatic build_body(input logic [7:0] op, input logic c, input int unsigned wd);
    outs_t      o;
    int         k;
    logic [3:0] mst;
    k = op_class(op);
    case (k)
      0, 1: begin
        o = z(S_EXEC); o.alu = op; o.alusrc = (k == 1);
        add(o, -1, -1, -1, 1'b0);
        o = z(S_ALUWB); o.rw = 1'b1; o.alusrc = (k == 1); o.ret = 1'b1;
        add(o, -1, -1, -1, 1'b0);
      end
      2, 3: begin
        o = z(S_ADDR); o.alu = ALU_ADD; o.alusrc = 1'b1;
        add(o, -1, -1, -1, 1'b0);
        mst = (k == 2) ? S_MEMRD : S_MEMWR;
        for (int unsigned i = 0; i < wd; i++) begin
          o = z(mst); o.req = 1'b1; o.asel = 1'b1; o.we = (k == 3);
          add(o, 0, -1, -1, 1'b0);
        end
        o = z(mst); o.req = 1'b1; o.asel = 1'b1; o.we = (k == 3); o.ret = (k == 3);
        add(o, 1, -1, -1, 1'b0);
        if (k == 2) begin
          o = z(S_LDWB); o.rw = 1'b1; o.m2r = 1'b1; o.ret = 1'b1;
          add(o, -1, -1, -1, 1'b0);
        end
      end
      4: begin
        o = z(S_BR); o.alu = op; o.pcw = c; o.pcsrc = 2'd1; o.ret = 1'b1;
        add(o, -1, int'(c), -1, 1'b0);
      end
      default: begin
        o = z(S_JMP); o.rw = 1'b1; o.jal = 1'b1; o.pcw = 1'b1; o.pcsrc = 2'd2;
        o.alusrc = 1'b1; o.alu = op; o.ret = 1'b1;
        add(o, -1, -1, -1, 1'b0);
      end
    endcase
  endtask

  task automatic run_instr(input string name, input logic [7:0] op, input logic c,
                           input int unsigned wf, input int unsigned wd);
    cur_op = op;
    build_fetch(wf);
    build_body(op, c, wd);
    play(name);
  endtask

  initial begin
    outs_t o;
    bus.halt = 1'b0; bus.mem_ack = 1'b1; bus.opcode = 8'h00; bus.cond = 1'b0;
    cur_op = 8'h00;

    // Reset held with halt low: FETCH would request, but outputs must be all zero
    repeat (2) @(negedge clk);
    #1 check("reset", sample(), z(S_FETCH));
    @(posedge clk);
    #2 rst_n = 1'b1;

    run_instr("alur",      8'h00, 1'b0, 0, 0);
    run_instr("lw_wait2",  8'h90, 1'b0, 0, 2);
    run_instr("sw",        8'h50, 1'b0, 0, 0);
    run_instr("br_taken",  8'h40, 1'b1, 0, 0);
    run_instr("br_not",    8'h40, 1'b0, 0, 0);
    run_instr("jal",       8'hB0, 1'b0, 0, 0);
    run_instr("alui",      8'h83, 1'b0, 1, 0);
    run_instr("sw_wait",   8'h5C, 1'b0, 2, 3);

    // halt in FETCH: no request, park in HALTED, resume once halt drops
    add(z(S_FETCH), -1, -1, 1, 1'b1);
    add(z(S_HALTED), -1, -1, 1, 1'b1);
    add(z(S_HALTED), -1, -1, 1, 1'b1);
    add(z(S_HALTED), -1, -1, 0, 1'b1);
    play("halt");
    run_instr("post_halt", 8'h81, 1'b0, 0, 0);

    for (int i = 0; i < 40; i++)
      run_instr($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));

    // Reset asserted while MEMWR waits for ack: request must vanish immediately
    cur_op = 8'h50;
    build_fetch(0);
    o = z(S_ADDR); o.alu = ALU_ADD; o.alusrc = 1'b1;
    add(o, -1, -1, -1, 1'b0);
    o = z(S_MEMWR); o.req = 1'b1; o.we = 1'b1; o.asel = 1'b1;
    add(o, 0, -1, -1, 1'b0);
    play("sw_abort");
    #2 rst_n = 1'b0;
    #1 check("abort_reset", sample(), z(S_FETCH));
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_instr("post_abort", 8'h07, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
